// File: rtl/booth_pp_accumulator.sv
// Multi-cycle carry-save reducer for radix-4 Booth partial products, with valid/ready on both sides.
// Optional BOOTH_PP_ACC_OVERLAP_EN lets a new set be accepted on the same edge the result is released.
module booth_pp_accumulator #(
  parameter int unsigned NUM_PP   = 16,
  parameter int unsigned PP_W     = 64,
  parameter int unsigned PP_GROUP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PP*PP_W-1:0] PP_In,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  output logic [PP_W-1:0]        Product,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic                   Busy
);

  localparam int unsigned NUM_GROUPS = NUM_PP / PP_GROUP;
  localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PP*PP_W-1:0]  hold_q, hold_d;
  logic [PP_W-1:0]         sum_q, sum_d;
  logic [PP_W-1:0]         carry_q, carry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PP_W-1:0]         product_q, product_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;

  logic [PP_W-1:0]         pp_sh [NUM_PP];
  logic [PP_W-1:0]         fold_sum, fold_carry;

  // Weight each held PP by 4^i; bits shifted past PP_W are dropped.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PP; i++) begin
      pp_sh[i] = hold_q[i*PP_W +: PP_W] << (2 * i);
    end
  end

  // Chain of 3:2 compressors folding the current group into the sum/carry pair.
  always_comb begin : fold
    logic [PP_W-1:0] x;
    logic [PP_W-1:0] s_n;
    logic [PP_W-1:0] c_n;
    fold_sum   = sum_q;
    fold_carry = carry_q;
    x          = '0;
    s_n        = '0;
    c_n        = '0;
    for (int unsigned j = 0; j < PP_GROUP; j++) begin
      x = '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        if (cnt_q == CNT_W'(g)) x = pp_sh[g*PP_GROUP + j];
      end
      s_n        = fold_sum ^ fold_carry ^ x;
      c_n        = ((fold_sum & fold_carry) | (fold_sum & x) | (fold_carry & x)) << 1;
      fold_sum   = s_n;
      fold_carry = c_n;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (In_Valid && In_Ready) begin
          hold_d  = PP_In;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sum_d   = fold_sum;
        carry_d = fold_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = RESOLVE;
      end
      RESOLVE: begin
        product_d   = sum_q + carry_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (Out_Ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef BOOTH_PP_ACC_OVERLAP_EN
          if (In_Valid) begin
            hold_d  = PP_In;
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == ACCUM) || (state_d == RESOLVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BOOTH_PP_ACC_OVERLAP_EN
  assign In_Ready  = in_ready_q | ((state_q == DONE) && Out_Ready);
`else
  assign In_Ready  = in_ready_q;
`endif
  assign Product   = product_q;
  assign Out_Valid = out_valid_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: expected products queued at accept, compared on output handshake.
module tb_booth_pp_accumulator;

  localparam int unsigned NUM_PP = 16;
  localparam int unsigned PP_W   = 64;

  logic                   clk;
  logic                   rst;
  logic [NUM_PP*PP_W-1:0] PP_In;
  logic                   In_Valid;
  logic                   In_Ready;
  logic [PP_W-1:0]        Product;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic                   Busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [PP_W-1:0] sbq [$];

  booth_pp_accumulator #(.NUM_PP(16), .PP_W(64), .PP_GROUP(4)) dut (
    .clk(clk), .rst(rst), .PP_In(PP_In), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Product(Product), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Busy(Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [NUM_PP*PP_W-1:0] p);
    logic [63:0] acc;
    logic [63:0] w;
    acc = '0;
    w   = 64'd1;
    for (int i = 0; i < NUM_PP; i++) begin
      acc = acc + p[i*PP_W +: PP_W] * w;
      w   = w * 64'd4;
    end
    return acc;
  endfunction

  function automatic logic [NUM_PP*PP_W-1:0] rand_set();
    logic [NUM_PP*PP_W-1:0] p;
    for (int i = 0; i < NUM_PP*2; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst && Out_Valid && Out_Ready) begin
      if (sbq.size() == 0) check("unexpected_out", Product, 64'hDEAD_DEAD_DEAD_DEAD);
      else check("product", Product, sbq.pop_front());
    end
  end

  // Called just after an active edge (+#1); returns #1 after the accept edge.
  task automatic send(input logic [NUM_PP*PP_W-1:0] p, input logic [63:0] exp, input bit push);
    int unsigned n;
    n = 0;
    while (!In_Ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 64'(n < 200), 64'd1);
    PP_In    = p;
    In_Valid = 1'b1;
    if (push) sbq.push_back(exp);
    @(posedge clk); #1;
    In_Valid = 1'b0;
    PP_In    = rand_set();
    check("busy_after_accept", 64'(Busy), 64'd1);
    check("in_ready_after_accept", 64'(In_Ready), 64'd0);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (Out_Valid) break;
    end
  endtask

  initial begin
    logic [NUM_PP*PP_W-1:0] p;
    logic [63:0]            held;
    int unsigned            lat;
    bit                     seen;

    rst       = 1'b0;
    PP_In     = '0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(In_Ready), 64'd1);
    check("rst_out_valid", 64'(Out_Valid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_product", Product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency and DONE stall
    p = '0;
    p[63:0] = 64'd5;
    send(p, 64'd5, 1'b1);
    wait_valid(lat);
    check("latency", 64'(lat), 64'd5);
    held = Product;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_product", Product, held);
      check("stall_valid", 64'(Out_Valid), 64'd1);
      check("stall_in_ready", 64'(In_Ready), 64'd0);
    end
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(Out_Valid), 64'd0);
    check("release_in_ready", 64'(In_Ready), 64'd1);
    check("release_busy", 64'(Busy), 64'd0);
    check("product_hold", Product, 64'd5);
    drain();

    // 7 x 7 Booth set
    p = '0;
    p[63:0]   = 64'hFFFF_FFFF_FFFF_FFF9;
    p[127:64] = 64'd14;
    send(p, 64'd49, 1'b1);
    drain();

    // Top partial product of -1
    p = '0;
    p[15*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    send(p, 64'hFFFF_FFFF_C000_0000, 1'b1);
    drain();

    // All ones
    for (int i = 0; i < NUM_PP; i++) p[i*64 +: 64] = 64'd1;
    send(p, 64'h0000_0000_5555_5555, 1'b1);
    drain();

    // Back-to-back random sets
    for (int k = 0; k < 6; k++) begin
      p = rand_set();
      send(p, model(p), 1'b1);
    end
    drain();

    // Abort in second ACCUM cycle
    p = '0;
    p[63:0] = 64'd9;
    send(p, 64'd0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_in_ready", 64'(In_Ready), 64'd1);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (Out_Valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    p = '0;
    p[63:0] = 64'd3;
    send(p, 64'd3, 1'b1);
    wait_valid(lat);
    check("latency_after_abort", 64'(lat), 64'd5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
